// File: rtl/pulse_meas.sv
// Pulse-train receiver: measures high width and period, checks tolerance, reports lock.
// Optional input synchronizer enabled by defining PULSE_MEAS_SYNC_EN.
module pulse_meas #(
    parameter int CNT_W      = 16,
    parameter int EXP_HIGH   = 1000,
    parameter int EXP_PERIOD = 5001,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_valid,
    output logic             period_ok,
    output logic             locked,
    output logic             timeout
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic signed [CNT_W:0] EH = EXP_HIGH[CNT_W:0];
    localparam logic signed [CNT_W:0] EP = EXP_PERIOD[CNT_W:0];
    localparam logic signed [CNT_W:0] TL = TOL[CNT_W:0];
    localparam logic [MC_W-1:0] LK = MC_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic din;
    logic s0, s1;
    logic rise, fall;
    state_t state, nxt;
    logic load, done, tmo;
    logic [CNT_W-1:0] period_cnt, high_cnt;
    logic [MC_W-1:0] mcnt, mc_nxt;
    logic signed [CNT_W:0] dh, dp, ah, ap;
    logic ok;

`ifdef PULSE_MEAS_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], pulse_in};
    end

    assign din = sync[1];
`else
    assign din = pulse_in;
`endif

    // Reset to 1 so a level already high at reset is not seen as a rise
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            s0 <= din;
            s1 <= s0;
        end
    end

    assign rise = s0 & ~s1;
    assign fall = ~s0 & s1;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        done = 1'b0;
        tmo  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    nxt  = HIGH;
                    load = 1'b1;
                end
            end
            HIGH: begin
                if (period_cnt == CMAX) begin
                    nxt = IDLE;
                    tmo = 1'b1;
                end else if (fall) begin
                    nxt = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    nxt  = HIGH;
                    load = 1'b1;
                    done = 1'b1;
                end else if (period_cnt == CMAX) begin
                    nxt = IDLE;
                    tmo = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // The fall cycle is the first low sample, so it does not add to the width
    always_ff @(posedge clk) begin
        if (!rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (load) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else if (state == HIGH || state == LOW) begin
            if (period_cnt != CMAX) period_cnt <= period_cnt + 1'b1;
            if (state == HIGH && !fall && high_cnt != CMAX)
                high_cnt <= high_cnt + 1'b1;
        end
    end

    always_comb begin
        dh = $signed({1'b0, high_cnt}) - EH;
        dp = $signed({1'b0, period_cnt}) - EP;
        ah = (dh < 0) ? -dh : dh;
        ap = (dp < 0) ? -dp : dp;
        ok = (ah <= TL) && (ap <= TL);
        if (!ok)             mc_nxt = '0;
        else if (mcnt == LK) mc_nxt = LK;
        else                 mc_nxt = mcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            meas_high   <= '0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            period_ok   <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            mcnt        <= '0;
        end else begin
            meas_valid <= done;
            timeout    <= tmo;
            if (done) begin
                meas_high   <= high_cnt;
                meas_period <= period_cnt;
                period_ok   <= ok;
                mcnt        <= mc_nxt;
                locked      <= (mc_nxt == LK);
            end else if (tmo) begin
                mcnt   <= '0;
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meas.sv
// Randomized self-checking bench for pulse_meas against an edge-level event model.
module tb_pulse_meas;

    localparam int CW   = 10;
    localparam int EH   = 100;
    localparam int EP   = 501;
    localparam int TL   = 2;
    localparam int LC   = 4;
    localparam int MAXV = (1 << CW) - 1;
`ifdef PULSE_MEAS_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in;
    logic [CW-1:0] meas_high, meas_period;
    logic          meas_valid, period_ok, locked, timeout;

    pulse_meas #(
        .CNT_W(CW), .EXP_HIGH(EH), .EXP_PERIOD(EP), .TOL(TL), .LOCK_CNT(LC)
    ) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .meas_high(meas_high), .meas_period(meas_period),
        .meas_valid(meas_valid), .period_ok(period_ok),
        .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tmo;
        int cyc;
        int h;
        int p;
        bit ok;
        bit lk;
    } ev_t;

    ev_t exq[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    bit armed = 0;
    bit last = 1;
    int r0 = 0;
    int f0 = 0;
    int mc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string tag, longint got, longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Model works on sample edges: rises at r0/r1 give P=r1-r0, width is first-low minus r0
    task automatic model(int e, bit lvl);
        ev_t ev;
        int h, p;
        bit ok;
        if (armed && (e - r0) == MAXV + 1) begin
            ev = '{tmo: 1'b1, cyc: e + SD, h: 0, p: 0, ok: 1'b0, lk: 1'b0};
            exq.push_back(ev);
            armed = 0;
            mc = 0;
        end
        if (lvl && !last) begin
            if (armed) begin
                p  = e - r0;
                h  = f0 - r0;
                ok = (iabs(h - EH) <= TL) && (iabs(p - EP) <= TL);
                mc = ok ? ((mc < LC) ? mc + 1 : LC) : 0;
                ev = '{tmo: 1'b0, cyc: e + 1 + SD, h: h, p: p, ok: ok, lk: (mc == LC)};
                exq.push_back(ev);
            end
            armed = 1;
            r0 = e;
        end
        if (!lvl && last) f0 = e;
        last = lvl;
    endtask

    task automatic step(bit lvl);
        pulse_in = lvl;
        if (rst) model(cyc + 1, lvl);
        else begin
            armed = 0;
            mc = 0;
            last = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic period(int h, int p);
        for (int i = 0; i < p; i++) step(i < h);
    endtask

    always @(negedge clk) begin
        if (exq.size() > 0 && exq[0].cyc < cyc) begin
            chk("missed_event", cyc, exq[0].cyc);
            void'(exq.pop_front());
        end
        if (rst && (meas_valid || timeout)) begin
            chk("valid_tmo_excl", meas_valid & timeout, 0);
            if (exq.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                ev_t ev;
                ev = exq.pop_front();
                chk("ev_kind", timeout, ev.tmo);
                chk("ev_cycle", cyc, ev.cyc);
                if (!ev.tmo) begin
                    chk("meas_high", meas_high, ev.h);
                    chk("meas_period", meas_period, ev.p);
                    chk("period_ok", period_ok, ev.ok);
                    chk("locked", locked, ev.lk);
                end else begin
                    chk("tmo_locked", locked, 0);
                end
            end
        end
    end

    initial begin
        int r, h, p;
        rst = 1'b0;
        pulse_in = 1'b0;
        repeat (4) step(0);
        chk("rst_meas_high", meas_high, 0);
        chk("rst_meas_period", meas_period, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_period_ok", period_ok, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b1;
        repeat (20) step(0);

        repeat (6) period(EH, EP);
        chk("train_locked", locked, mc == LC);

        period(EH + 3, EP);
        repeat (5) period(EH, EP);
        chk("relock", locked, mc == LC);

        period(EH - 2, EP + 2);
        period(EH, EP - 3);
        period(EH, EP);
        period(EH, EP);

        period(EH, 1500);
        chk("tmo_unlocked", locked, 0);
        repeat (3) period(EH, EP);

        period(EH, MAXV);
        period(EH, EP);

        repeat (30) step(1);
        rst = 1'b0;
        repeat (3) step(1);
        rst = 1'b1;
        repeat (40) step(1);
        repeat (431) step(0);
        repeat (3) period(EH, EP);

        repeat (40) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                h = 1;
                p = 2;
            end else if (r == 1) begin
                h = $urandom_range(1, 20);
                p = h + $urandom_range(1, 30);
            end else begin
                h = EH - 4 + $urandom_range(0, 8);
                p = EP - 4 + $urandom_range(0, 8);
            end
            period(h, p);
        end
        step(1);
        repeat (20) step(0);
        chk("pending_events", exq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_meas.md
# pulse_meas

Pulse-train receiver and checker for the gating pulse used in the BPSK simulation. It samples a single-bit pulse input, measures the high width and rising-edge-to-rising-edge period of every cycle, and compares each measurement against the expected values within a tolerance. It reports a lock flag after a run of consecutive good periods. It sits on the receive side of the pulse link and runs in the same clock domain as the pulse generator.

## Interface
- `CNT_W`, 16: width of the measurement counters and outputs.
- `EXP_HIGH`, 1000: expected high width, in clk cycles.
- `EXP_PERIOD`, 5001: expected period, in clk cycles.
- `TOL`, 2: allowed absolute deviation for both width and period, in cycles.
- `LOCK_CNT`, 4: number of consecutive matching periods required to assert `locked`.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `pulse_in`  in  1: pulse train, synchronous to `clk` unless the sync option is compiled in.
- `meas_high`  out  CNT_W: latched high width of the last completed period.
- `meas_period`  out  CNT_W: latched length of the last completed period.
- `meas_valid`  out  1: one-cycle strobe when `meas_high` and `meas_period` update.
- `period_ok`  out  1: result of the tolerance check for the last measurement. Updates with `meas_valid`.
- `locked`  out  1: high when LOCK_CNT consecutive measurements have matched.
- `timeout`  out  1: one-cycle strobe when the period counter saturates.

## Operation
- Sampling: `s0 <= pulse_in`, `s1 <= s0`.
  - `rise = s0 & ~s1`; `fall = ~s0 & s1`.
  - `s0` and `s1` reset to 1. This prevents a high level present at reset from being taken as an edge.
- FSM states: IDLE, HIGH, LOW. Reset state is IDLE.
  - IDLE: wait for `rise`. On `rise`, go to HIGH, set `period_cnt<=1` and `high_cnt<=1`. No `meas_valid` is issued.
  - HIGH: `period_cnt` and `high_cnt` each increment by 1 per cycle. On `fall`, go to LOW.
  - LOW: `period_cnt` increments by 1 per cycle; `high_cnt` holds.
  - LOW on `rise`:
    - latch `meas_period<=period_cnt` and `meas_high<=high_cnt`;
    - pulse `meas_valid`;
    - update `period_ok`, the match counter and `locked`;
    - reload both counters to 1 and go to HIGH.
- Counter saturation:
  - Both counters saturate at 2^CNT_W−1.
  - If `period_cnt` is at its maximum in HIGH or LOW and no `rise` occurs, pulse `timeout`, clear the match counter and `locked`, and go to IDLE. `meas_*` outputs hold their values.
  - If `rise` and saturation occur in the same cycle, `rise` wins. The saturated value is reported and fails the check.
- Tolerance check:
  - `match = |meas_high−EXP_HIGH|<=TOL && |meas_period−EXP_PERIOD|<=TOL`.
  - Compute the differences at CNT_W+1 bits signed so there is no wrap.
- Lock logic:
  - On a matching `meas_valid`, the match counter increments, saturating at LOCK_CNT.
  - On a non-matching `meas_valid`, the match counter clears to 0.
  - `locked = (match counter == LOCK_CNT)`. It is registered and updates in the same cycle as `meas_valid`.
- Reset mid-operation:
  - All state is cleared and the FSM returns to IDLE.
  - After reset, the first `rise` only arms the block; the first measurement comes at the second `rise`.

## Timing
- Output reset values:
  - `meas_high=0`, `meas_period=0`;
  - `meas_valid=0`, `period_ok=0`, `locked=0`, `timeout=0`.
- Latency: if pulse_in is first sampled high at clk edge n, `meas_valid`, `meas_*`, `period_ok` and `locked` are valid after edge n+1 and hold for one cycle. They are high from edge n+1 to edge n+2.
- Measurement semantics:
  - A pulse sampled high for H edges in a P-edge period gives `meas_high=H` and `meas_period=P`.
  - Minimum measurable values are H=1 and P=2.
- `timeout` asserts 2^CNT_W−1 cycles after the last `rise`.
- At most one `meas_valid` is issued per period. `meas_valid` and `timeout` are never high in the same cycle.

## Configuration
- `PULSE_MEAS_SYNC_EN`: when defined, `pulse_in` passes through a 2-flop synchronizer before `s0`.
  - Both synchronizer flops reset to 1.
  - All latencies from `pulse_in` increase by 2 cycles. Measured widths and periods are unchanged.
- Without the macro, `pulse_in` feeds `s0` directly and must be synchronous to `clk`.

## Test plan
- Default train (1000 high, 5001 period) after reset:
  - the first `meas_valid` comes at the second rise, with `meas_high=1000`, `meas_period=5001`, `period_ok=1`;
  - `locked=1` in the cycle of the 4th `meas_valid`.
- Locked, then one period with high width 1003:
  - `period_ok=0` and `locked=0` on that strobe;
  - `locked` returns after 4 further good periods.
- Tolerance edges:
  - high 998 with period 5003 gives `period_ok=1`;
  - high 1000 with period 4998 gives `period_ok=0`.
- Locked, then `pulse_in` held low:
  - `timeout` pulses once 65535 cycles after the last rise, and `locked=0`;
  - the next rise only arms, and the first new `meas_valid` comes one period later.
- Reset asserted mid-pulse with `pulse_in` high and released while it is still high:
  - no rise is detected on release;
  - the first `meas_valid` comes at the second full rise afterwards, with correct values.
- With `PULSE_MEAS_SYNC_EN` defined, the default train gives identical values, with `meas_valid` 2 cycles later than without the macro.
